// File: rtl/seq_multiplier_param_pkg.sv
// Shared definitions for the parametrised shift-add multiplier:
// FSM state type and its encodings.
package seq_multiplier_param_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE    = 2'd0;
   localparam state_t ST_SETUP   = 2'd1;
   localparam state_t ST_COMPUTE = 2'd2;
   localparam state_t ST_DONE    = 2'd3;

endpackage

// File: rtl/seq_multiplier_param_counter.sv
// Synchronous up-counter with clear and enable, used as the iteration
// counter of the shift-add multiplier.
module param_counter #(
   parameter int CW = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clr,
   input  logic          en,
   output logic [CW-1:0] count
);

   logic [CW-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr)     count_d = '0;
      else if (en) count_d = count_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) count_q <= '0;
      else       count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/seq_multiplier_param.sv
// Sequential shift-add multiplier, one partial product per cycle, with
// ready/start/done handshake, optional signed mode and optional early exit.
module seq_multiplier_param
   import seq_multiplier_param_pkg::*;
#(
   parameter int  WIDTH      = 16,
   parameter bit  SIGNED_EN  = 1'b1,
   parameter bit  EARLY_EXIT = 1'b0,
   localparam int CW         = $clog2(WIDTH + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               signed_mode,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               ready,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product,
   output logic [1:0]         state,
   output logic [CW-1:0]      count
);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
   logic               sm_q, sm_d, neg_q, neg_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d, acc_q, acc_d, product_q, product_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;

   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [2*WIDTH-1:0] acc_next;
   logic               last_iter;
   logic               cnt_clr, cnt_en;
   logic [CW-1:0]      count_w;

   param_counter #(.CW(CW)) u_counter (
      .clk   (clk),
      .reset (reset),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .count (count_w)
   );

   // Magnitudes are unsigned WIDTH-bit, so the most negative operand maps to 2^(WIDTH-1).
   assign a_mag     = (sm_q && a_q[WIDTH-1]) ? -a_q : a_q;
   assign b_mag     = (sm_q && b_q[WIDTH-1]) ? -b_q : b_q;
   assign acc_next  = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign last_iter = (count_w == CW'(WIDTH - 1)) ||
                      (EARLY_EXIT && (mplier_q[WIDTH-1:1] == '0));

   // NOTE: every _d gets its hold value first so no path through the case infers a latch.
   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      sm_d      = sm_q;
      neg_d     = neg_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      acc_d     = acc_q;
      product_d = product_q;
      cnt_clr   = 1'b0;
      cnt_en    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               sm_d    = signed_mode & SIGNED_EN;
               state_d = ST_SETUP;
            end
         end
         ST_SETUP: begin
            mcand_d  = {{WIDTH{1'b0}}, a_mag};
            mplier_d = b_mag;
            neg_d    = sm_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
            acc_d    = '0;
            cnt_clr  = 1'b1;
            state_d  = ST_COMPUTE;
         end
         ST_COMPUTE: begin
            acc_d    = acc_next;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_en   = 1'b1;
            if (last_iter) begin
               product_d = neg_q ? -acc_next : acc_next;
               state_d   = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: the datapath registers are cleared by reset too, so an aborted operation leaves nothing behind.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         a_q       <= '0;
         b_q       <= '0;
         sm_q      <= 1'b0;
         neg_q     <= 1'b0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         acc_q     <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         sm_q      <= sm_d;
         neg_q     <= neg_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         acc_q     <= acc_d;
         product_q <= product_d;
      end
   end

   assign ready   = (state_q == ST_IDLE);
   assign busy    = (state_q == ST_SETUP) || (state_q == ST_COMPUTE);
   assign done    = (state_q == ST_DONE);
   assign product = product_q;
   assign state   = state_q;
   assign count   = count_w;

endmodule
